// File: rtl/countgen.sv
// Wishbone-slave binary count generator driving a bidirectional pin bank.
// A tick counter divides clk_i by PERIOD. Each wrap of the tick counter
// increments COUNT, and COUNT drives the pins whose output enable is set.
// The block also gives pin readback and a rising-edge counter on one
// selectable pin.
module countgen #(
    parameter int NPINS = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [5:0]  adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    output logic        ack_o,
    inout  wire  [NPINS-1:0] countgen_io
);

    localparam int SW = $clog2(NPINS);

    logic [NPINS-1:0] oe;
    logic [SW-1:0]    edge_sel;
    logic [31:0]      period;
    logic [NPINS-1:0] count;
    logic [31:0]      tick;
    logic [NPINS-1:0] sync1;
    logic [NPINS-1:0] sync2;
    logic [31:0]      edges;

    logic [3:0] reg_sel;
    logic       wr, wr_ctrl, wr_period, wr_count, wr_edges;
    logic       wrap, rise;

    assign reg_sel   = adr_i[5:2];
    assign wr        = cyc_i & stb_i & we_i;
    assign wr_ctrl   = wr && (reg_sel == 4'd0);
    assign wr_period = wr && (reg_sel == 4'd1);
    assign wr_count  = wr && (reg_sel == 4'd2);
    assign wr_edges  = wr && (reg_sel == 4'd5);

    // A PERIOD write restarts the tick phase, so it also suppresses a wrap on that edge.
    assign wrap = (period != 32'd0) && (tick == period - 32'd1) && !wr_period;
    // sync1 becomes the new PINS on this edge, and sync2 holds the current PINS.
    assign rise = sync1[edge_sel] & ~sync2[edge_sel];

    assign ack_o = cyc_i & stb_i & ~rst_i;

    // Pins with OE set drive their COUNT bit. All other pins float as inputs.
    for (genvar i = 0; i < NPINS; i++) begin : g_pin
        assign countgen_io[i] = oe[i] ? count[i] : 1'bz;
    end

    // Register file, tick divider, COUNT, synchronizers and edge counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            oe       <= '0;
            edge_sel <= '0;
            period   <= '0;
            count    <= '0;
            tick     <= '0;
            sync1    <= '0;
            sync2    <= '0;
            edges    <= '0;
        end else begin
            sync1 <= countgen_io;
            sync2 <= sync1;

            if (wr_ctrl) begin
                oe       <= dat_i[NPINS-1:0];
                edge_sel <= dat_i[8 +: SW];
            end
            if (wr_period)
                period <= dat_i;

            if (wr_period || period == 32'd0 || wrap)
                tick <= '0;
            else
                tick <= tick + 32'd1;

            // A preset has priority over a wrap on the same edge.
            if (wr_count)
                count <= dat_i[NPINS-1:0];
            else if (wrap)
                count <= count + 1'b1;

            // A clear has priority over a coincident rising edge.
            if (wr_edges)
                edges <= '0;
            else if (rise)
                edges <= edges + 32'd1;
        end
    end

    // Zero-wait-state read mux. Unused bits and unmapped addresses read 0.
    always_comb begin
        dat_o = '0;
        case (reg_sel)
            4'd0: begin
                dat_o[NPINS-1:0] = oe;
                dat_o[8 +: SW]   = edge_sel;
            end
            4'd1: dat_o = period;
            4'd2: dat_o[NPINS-1:0] = count;
            4'd3: dat_o[NPINS-1:0] = sync2;
            4'd4: dat_o = tick;
            4'd5: dat_o = edges;
            default: dat_o = '0;
        endcase
    end

endmodule

// File: tb/tb_countgen.sv
// Self-checking bench for countgen. It uses randomized bus traffic and pin
// activity, checked against a behavioural model. Directed scenarios cover
// reset, period changes, COUNT wrap, the edge counter and PERIOD = 0.
module tb_countgen;

    localparam int NPINS = 8;

    logic        clk = 1'b0;
    logic        rst, cyc, stb, we;
    logic [5:0]  adr;
    logic [31:0] dat_in;
    wire  [31:0] dat_out;
    wire         ack;
    wire  [7:0]  pio;

    logic [7:0] tb_en, tb_val;
    logic       loop;
    logic       ext7 = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference state.
    logic [7:0]  m_oe, m_count, m_p1, m_p2;
    logic [2:0]  m_sel;
    logic [31:0] m_period, m_tick, m_edges;

    always #5 clk = ~clk;

    countgen #(.NPINS(NPINS)) dut (
        .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
        .adr_i(adr), .dat_i(dat_in), .dat_o(dat_out), .ack_o(ack),
        .countgen_io(pio)
    );

    // External drivers. In loop mode, pin 7 is tied back to pin 0.
    for (genvar i = 0; i < 8; i++) begin : g_drv
        if (i == 7) begin : g_loop
            assign pio[i] = tb_en[i] ? (loop ? ext7 : tb_val[i]) : 1'bz;
        end else begin : g_plain
            assign pio[i] = tb_en[i] ? tb_val[i] : 1'bz;
        end
    end

    // Pin 0 only changes just after a rising edge, so a half-cycle copy looks like a wire to the synchronizer.
    always @(negedge clk) ext7 <= pio[0];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_pins();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = m_oe[i] ? m_count[i] : tb_val[i];
        if (loop && !m_oe[7]) p[7] = p[0];
        return p;
    endfunction

    function automatic logic [31:0] model_read(input logic [5:0] a);
        case (a[5:2])
            4'd0: return {21'd0, m_sel, m_oe};
            4'd1: return m_period;
            4'd2: return {24'd0, m_count};
            4'd3: return {24'd0, m_p2};
            4'd4: return m_tick;
            4'd5: return m_edges;
            default: return 32'd0;
        endcase
    endfunction

    // This task runs just after a rising edge. The stimulus variables still hold their pre-edge values.
    task automatic model_update();
        logic [7:0] pv;
        logic       w, wrap, rise, pwr;
        logic [3:0] r;
        pv = model_pins();
        if (rst) begin
            m_oe = 0; m_sel = 0; m_period = 0; m_count = 0;
            m_tick = 0; m_edges = 0; m_p1 = 0; m_p2 = 0;
            return;
        end
        w    = cyc & stb & we;
        r    = adr[5:2];
        pwr  = w && r == 4'd1;
        rise = m_p1[m_sel] && !m_p2[m_sel];
        wrap = m_period != 0 && m_tick == m_period - 1 && !pwr;
        m_tick = (pwr || m_period == 0 || wrap) ? 32'd0 : m_tick + 1;
        if (w && r == 4'd2) m_count = dat_in[7:0];
        else if (wrap) m_count = m_count + 8'd1;
        if (w && r == 4'd5) m_edges = 0;
        else if (rise) m_edges = m_edges + 1;
        if (w && r == 4'd0) begin m_oe = dat_in[7:0]; m_sel = dat_in[10:8]; end
        if (pwr) m_period = dat_in;
        m_p2 = m_p1;
        m_p1 = pv;
    endtask

    // One clock. The task enters and leaves at a falling edge.
    task automatic clk_step();
        @(posedge clk);
        #1;
        model_update();
        tb_en = ~m_oe;
        @(negedge clk);
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        cyc = 1; stb = 1; we = 1; adr = a; dat_in = d;
        clk_step();
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd(input logic [5:0] a, output logic [31:0] v);
        cyc = 1; stb = 1; we = 0; adr = a;
        #1;
        v = dat_out;
        cyc = 0; stb = 0;
    endtask

    task automatic rd_chk(input logic [5:0] a);
        cyc = 1; stb = 1; we = 0; adr = a;
        #1;
        chk($sformatf("rd%02h", a), dat_out, model_read(a));
        chk("ack", {31'd0, ack}, 32'd1);
        cyc = 0; stb = 0;
    endtask

    // Clocks between two consecutive changes of PINS[b].
    task automatic measure(input int b, input int exp, input string tag);
        logic prev;
        int   n;
        cyc = 1; stb = 1; we = 0; adr = 6'h0C;
        #1;
        prev = dat_out[b]; n = 0;
        while (dat_out[b] == prev && n < 1000) begin clk_step(); #1; n++; end
        prev = dat_out[b]; n = 0;
        while (dat_out[b] == prev && n < 1000) begin clk_step(); #1; n++; end
        chk(tag, n, exp);
        cyc = 0; stb = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, c0;
        logic [5:0]  a;
        int          n;

        rst = 1; cyc = 0; stb = 0; we = 0; adr = 0; dat_in = 0;
        loop = 0; tb_en = 8'hFF; tb_val = 8'hA5;
        m_oe = 0; m_sel = 0; m_period = 0; m_count = 0;
        m_tick = 0; m_edges = 0; m_p1 = 0; m_p2 = 0;

        // Reset: every address reads 0, ack is held low, and the pins float.
        @(negedge clk);
        clk_step(); clk_step();
        for (int i = 0; i < 16; i++) begin
            cyc = 1; stb = 1; adr = 6'(i * 4);
            #1;
            chk($sformatf("rst_rd%02h", i * 4), dat_out, 32'd0);
            chk("rst_ack", {31'd0, ack}, 32'd0);
        end
        cyc = 0; stb = 0;
        rst = 0;
        repeat (3) clk_step();
        rd(6'h0C, v);
        chk("pins_hiz", v, 32'hA5);

        // OE mask and period, with pin 7 looped from pin 0.
        wr(6'h00, 32'h7F);
        wr(6'h04, 32'd24);
        loop = 1;
        repeat (5) clk_step();
        measure(0, 24, "half0_24");
        measure(1, 48, "half1_48");
        for (int i = 0; i < 30; i++) begin rd_chk(6'h0C); clk_step(); end

        // Change the period while the counter is running.
        wr(6'h04, 32'd280);
        rd(6'h10, v);
        chk("tick_after_280", v, 32'd0);
        measure(0, 280, "half0_280");
        wr(6'h04, 32'd272);
        rd(6'h10, v);
        chk("tick_after_272", v, 32'd0);
        measure(0, 272, "half0_272");

        // COUNT wraps from 0xFF to 0x00.
        wr(6'h04, 32'd2);
        wr(6'h08, 32'hFE);
        rd_chk(6'h08);
        n = 0;
        rd(6'h08, v);
        while (v != 32'hFF && n < 8) begin clk_step(); rd(6'h08, v); n++; end
        chk("count_ff", v, 32'hFF);
        n = 0;
        while (v != 32'h00 && n < 8) begin clk_step(); rd(6'h08, v); n++; end
        chk("ff_to_00_clks", n, 32'd2);
        clk_step(); clk_step();
        rd(6'h0C, v);
        chk("pins_fall", {25'd0, v[6:0]}, 32'd0);
        rd_chk(6'h0C);

        // Edge counter on pin 7, looped from pin 0.
        wr(6'h00, 32'h77F);
        wr(6'h04, 32'd10);
        wr(6'h14, 32'd0);
        repeat (400) clk_step();
        rd(6'h14, v);
        chk("edges_20pm1", {31'd0, (v >= 19 && v <= 21)}, 32'd1);
        rd_chk(6'h14);
        wr(6'h14, 32'hDEAD);
        rd(6'h14, v);
        chk("edges_clr", v, 32'd0);

        // PERIOD = 0 freezes both TICK and COUNT.
        wr(6'h04, 32'd0);
        rd(6'h10, v);
        chk("p0_tick", v, 32'd0);
        rd(6'h08, c0);
        rd_chk(6'h08);
        repeat (20) clk_step();
        rd(6'h10, v);
        chk("p0_tick_held", v, 32'd0);
        rd(6'h08, v);
        chk("p0_count_held", v, c0);

        // Reset in the middle of a run.
        wr(6'h04, 32'd3);
        repeat (10) clk_step();
        loop = 0; rst = 1;
        clk_step();
        for (int i = 0; i < 16; i++) begin
            cyc = 1; stb = 1; adr = 6'(i * 4);
            #1;
            chk($sformatf("mid_rst_rd%02h", i * 4), dat_out, 32'd0);
        end
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        cyc = 0; stb = 0;
        rst = 0;
        tb_val = 8'h3C;
        repeat (3) clk_step();
        rd(6'h0C, v);
        chk("pins_hiz2", v, 32'h3C);

        // Randomized traffic, including writes to read-only and unmapped addresses.
        for (int it = 0; it < 400; it++) begin
            tb_val = 8'($urandom);
            case ($urandom_range(0, 5))
                0: begin
                    a = 6'($urandom_range(0, 15) * 4) | 6'($urandom_range(0, 3));
                    if (a[5:2] == 4'd1) wr(a, 32'($urandom_range(0, 6)));
                    else wr(a, $urandom);
                end
                1: wr(6'h04, 32'($urandom_range(0, 5)));
                2: wr(6'h00, $urandom);
                3: if ($urandom_range(0, 31) == 0) begin
                       rst = 1; clk_step(); rst = 0;
                   end else clk_step();
                default: clk_step();
            endcase
            rd_chk(6'($urandom_range(0, 15) * 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
